kron_sched: RTL and testbench

KRON_SCHED -- requirements
Module: kron_sched

---
 rtl/kron_sched.sv | 135 +++++++++++++
 tb/tb_kron_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kron_sched.sv
// Purpose: round-robin front end for a masked kronecker_d2 unit; issues 3-share bytes and collects results in a FWFT FIFO.
// Latency: a request issued at edge E is pushed at edge E+LAT+1; rsp_valid rises the cycle after the push.
// Backpressure: issue needs fresh randomness and a credit (FIFO entries + inflight < DEPTH), so a stalled consumer throttles requesters.
module kron_sched #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [23:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_data,
  output logic        req1_ready,
  input  logic [20:0] rnd_in,
  input  logic        rnd_valid,
  input  logic [23:0] idle_fill,
  output logic [23:0] kron_inp,
  output logic [20:0] kron_rnd,
  input  logic [2:0]  kron_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [2:0]  rsp_out,
  input  logic        rsp_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic          last_q, last_d;
  logic [23:0]   kron_inp_q, kron_inp_d;
  logic [20:0]   kron_rnd_q, kron_rnd_d;
  logic [LAT:0]  sh_vld_q, sh_vld_d;
  logic [LAT:0]  sh_id_q, sh_id_d;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0]    inflight;
  logic          credit;
  logic          grant0, grant1;
  logic          hs0, hs1, issue;
  logic          push, pop;

  // Credit: everything in the shadow pipe plus everything parked in the FIFO must fit in DEPTH.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++) begin
      inflight = inflight + 8'(sh_vld_q[i]);
    end
    credit = (8'(cnt_q) + inflight) < 8'(DEPTH);
  end

  // Round-robin grant; last_q=1 means req1 was served last, so req0 wins a tie.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_q);
    grant1     = req1_valid & (~req0_valid | ~last_q);
    req0_ready = grant0 & rnd_valid & credit & ~rst;
    req1_ready = grant1 & rnd_valid & credit & ~rst;
    hs0        = req0_valid & req0_ready;
    hs1        = req1_valid & req1_ready;
    issue      = hs0 | hs1;
    push       = sh_vld_q[LAT];
    rsp_valid  = (cnt_q != '0) & ~rst;
    pop        = rsp_valid & rsp_ready;
  end

  // Next state: the unit always sees fresh shares (request or filler) and fresh randomness.
  always_comb begin
    last_d     = issue ? hs1 : last_q;
    kron_inp_d = idle_fill;
    if (hs0) begin
      kron_inp_d = req0_data;
    end else if (hs1) begin
      kron_inp_d = req1_data;
    end
    kron_rnd_d = rnd_in;
    sh_vld_d   = {sh_vld_q[LAT-1:0], issue};
    sh_id_d    = {sh_id_q[LAT-1:0], hs1};

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {sh_id_q[LAT], kron_out};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset drops anything still in flight so it never reaches the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      kron_inp_q <= '0;
      kron_rnd_q <= '0;
      sh_vld_q   <= '0;
      sh_id_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      last_q     <= last_d;
      kron_inp_q <= kron_inp_d;
      kron_rnd_q <= kron_rnd_d;
      sh_vld_q   <= sh_vld_d;
      sh_id_q    <= sh_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Response storage holds output shares exactly as delivered; validity lives in cnt_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign kron_inp = kron_inp_q;
  assign kron_rnd = kron_rnd_q;
  assign rsp_id   = mem_q[rd_ptr_q][3];
  assign rsp_out  = mem_q[rd_ptr_q][2:0];

endmodule

// File: tb/tb_kron_sched.sv
// Bench for kron_sched: table of per-cycle vectors plus directed multi-cycle sequences.
// A behavioural kronecker_d2 model (LAT-deep pipe) feeds kron_out.
module tb_kron_sched;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [20:0] rnd_in;
  logic        rnd_valid;
  logic [23:0] idle_fill;
  logic [23:0] kron_inp;
  logic [20:0] kron_rnd;
  logic [2:0]  kron_out;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [2:0]  rsp_out;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pops = 0;
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  kron_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .idle_fill(idle_fill),
    .kron_inp(kron_inp), .kron_rnd(kron_rnd), .kron_out(kron_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_ready(rsp_ready)
  );

  // Masked Kronecker delta model: XOR of outputs is 1 iff the unmasked byte is zero.
  function automatic logic [2:0] kron_f(input logic [23:0] s, input logic [20:0] r);
    logic d;
    d = ((s[23:16] ^ s[15:8] ^ s[7:0]) == 8'h00);
    return {d ^ r[0] ^ r[1], r[1], r[0]};
  endfunction

  logic [2:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= kron_f(kron_inp, kron_rnd);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign kron_out = pipe[LAT-1];

  typedef struct {
    logic        rst;
    logic        r0v;
    logic [23:0] r0d;
    logic        r1v;
    logic [23:0] r1d;
    logic        rndv;
    logic        rrdy;
    logic        e0;
    logic        e1;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] mk(input logic [7:0] val);
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    return {val ^ a ^ b, a, b};
  endfunction

  function automatic logic dl(input logic [23:0] s);
    return (s[23:16] ^ s[15:8] ^ s[7:0]) == 8'h00;
  endfunction

  function automatic vec_t mkv(input int i, input logic rs, input logic r0v, input logic r1v,
                               input logic rndv, input logic rrdy, input logic e0, input logic e1);
    vec_t v;
    v.rst  = rs;
    v.r0v  = r0v;
    v.r0d  = mk((i % 3 == 0) ? 8'h00 : 8'(i * 37 + 1));
    v.r1v  = r1v;
    v.r1d  = mk((i % 4 == 1) ? 8'h00 : 8'(i * 53 + 7));
    v.rndv = rndv;
    v.rrdy = rrdy;
    v.e0   = e0;
    v.e1   = e1;
    return v;
  endfunction

  function automatic vec_t idl(input logic rrdy);
    return mkv(0, 1'b0, 1'b0, 1'b0, 1'b1, rrdy, 1'b0, 1'b0);
  endfunction

  // One clock cycle: drive at negedge, check readies and pops mid-cycle, check registered outputs after the edge.
  task automatic cyc(input vec_t v);
    logic [1:0]  e;
    logic [23:0] ei;
    logic [20:0] er;
    @(negedge clk);
    rst        = v.rst;
    req0_valid = v.r0v;
    req0_data  = v.r0d;
    req1_valid = v.r1v;
    req1_data  = v.r1d;
    rnd_valid  = v.rndv;
    rsp_ready  = v.rrdy;
    idle_fill  = 24'($urandom);
    rnd_in     = 21'($urandom);
    #1;
    check("req0_ready", 32'(req0_ready), 32'(v.e0));
    check("req1_ready", 32'(req1_ready), 32'(v.e1));
    if (v.rst) check("rsp_valid_in_rst", 32'(rsp_valid), 32'(0));
    if (rsp_valid && v.rrdy) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e[1]));
        check("rsp_xor", 32'(^rsp_out), 32'(e[0]));
      end
    end
    ei = idle_fill;
    er = rnd_in;
    if (v.r0v && v.e0) begin
      ei = v.r0d;
      exp_q.push_back({1'b0, dl(v.r0d)});
    end else if (v.r1v && v.e1) begin
      ei = v.r1d;
      exp_q.push_back({1'b1, dl(v.r1d)});
    end
    if (v.rst) begin
      ei = '0;
      er = '0;
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check("kron_inp", 32'(kron_inp), 32'(ei));
    check("kron_rnd", 32'(kron_rnd), 32'(er));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   p0;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    rnd_in = '0; rnd_valid = 1'b0; idle_fill = '0; rsp_ready = 1'b0;

    // Arbitration, credit and randomness gating, starting the first cycle after reset.
    //             i   rst  r0v  r1v  rndv rrdy e0   e1
    tbl[0]  = mkv(0,  0,   1,   1,   1,   1,   1,   0);
    tbl[1]  = mkv(1,  0,   1,   1,   1,   1,   0,   1);
    tbl[2]  = mkv(2,  0,   1,   0,   1,   1,   1,   0);
    tbl[3]  = mkv(3,  0,   1,   0,   1,   1,   1,   0);
    tbl[4]  = mkv(4,  0,   1,   1,   1,   1,   0,   0);
    tbl[5]  = mkv(5,  0,   1,   1,   1,   1,   0,   0);
    tbl[6]  = mkv(6,  0,   1,   1,   1,   1,   0,   0);
    tbl[7]  = mkv(7,  0,   1,   1,   1,   1,   0,   1);
    tbl[8]  = mkv(8,  0,   1,   1,   1,   1,   1,   0);
    tbl[9]  = mkv(9,  0,   0,   1,   0,   1,   0,   0);
    tbl[10] = mkv(10, 0,   0,   1,   0,   1,   0,   0);
    tbl[11] = mkv(11, 0,   0,   1,   0,   1,   0,   0);
    tbl[12] = mkv(12, 0,   0,   1,   1,   1,   0,   1);
    tbl[13] = mkv(13, 0,   0,   0,   1,   1,   0,   0);
    tbl[14] = mkv(14, 0,   1,   0,   1,   1,   1,   0);
    tbl[15] = mkv(15, 0,   0,   1,   1,   1,   0,   1);
    tbl[16] = mkv(16, 0,   1,   1,   1,   1,   1,   0);
    tbl[17] = mkv(17, 0,   1,   1,   1,   1,   0,   0);

    // Reset: readies held low even with valid requests and randomness.
    cyc(mkv(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc(mkv(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    check("rsp_valid_after_rst", 32'(rsp_valid), 32'(0));

    for (int i = 0; i < 18; i++) cyc(tbl[i]);
    for (int i = 0; i < 12; i++) cyc(idl(1'b1));
    check("table_drain_left", 32'(exp_q.size()), 32'(0));
    check("table_drain_valid", 32'(rsp_valid), 32'(0));

    // Single request latency and delta values (0x00 -> 1, 0x25 -> 0).
    v = idl(1'b0); v.r0v = 1'b1; v.r0d = mk(8'h00); v.e0 = 1'b1;
    cyc(v);
    for (int k = 1; k <= LAT + 1; k++) begin
      check("lat_valid_low", 32'(rsp_valid), 32'(0));
      cyc(idl(1'b0));
    end
    check("lat_valid_high", 32'(rsp_valid), 32'(1));
    check("lat_id", 32'(rsp_id), 32'(0));
    check("lat_xor_zero_byte", 32'(^rsp_out), 32'(1));
    v = idl(1'b1); v.r0v = 1'b1; v.r0d = mk(8'h25); v.e0 = 1'b1;
    cyc(v);
    for (int k = 1; k <= LAT + 1; k++) begin
      check("lat2_valid_low", 32'(rsp_valid), 32'(0));
      cyc(idl(1'b1));
    end
    check("lat2_valid_high", 32'(rsp_valid), 32'(1));
    check("lat2_xor_0x25", 32'(^rsp_out), 32'(0));
    cyc(idl(1'b1));

    // Credit exhaustion with a stalled consumer, then one pop buys exactly one issue.
    for (int k = 0; k < 4; k++)
      cyc(mkv(20 + k, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, (k % 2 == 1), (k % 2 == 0)));
    for (int k = 0; k < 8; k++)
      cyc(mkv(30 + k, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    check("credit_full_valid", 32'(rsp_valid), 32'(1));
    cyc(mkv(40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc(mkv(41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 4; k++) cyc(idl(1'b0));
    // Push of the late request lands in the same cycle as this pop, with three entries queued.
    cyc(idl(1'b1));
    check("pushpop_valid", 32'(rsp_valid), 32'(1));
    p0 = pops;
    for (int k = 0; k < 8; k++) cyc(idl(1'b1));
    check("pushpop_count", 32'(pops - p0), 32'(3));
    check("pushpop_left", 32'(exp_q.size()), 32'(0));

    // Reset mid-flight: two issues, reset two cycles later, nothing may come out.
    cyc(mkv(50, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    cyc(mkv(51, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    cyc(idl(1'b1));
    v = idl(1'b1); v.rst = 1'b1;
    cyc(v);
    for (int k = 0; k < 10; k++) begin
      check("flush_valid_low", 32'(rsp_valid), 32'(0));
      cyc(idl(1'b1));
    end
    // Issue is possible straight after reset.
    cyc(mkv(60, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    for (int k = 0; k < 8; k++) cyc(idl(1'b1));
    check("final_left", 32'(exp_q.size()), 32'(0));
    check("final_valid", 32'(rsp_valid), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
